// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core definitions used by the scoreboard-clear scheduler.
package bsg_vanilla_pkg;

  localparam int RV32_reg_addr_width_gp = 5;

  localparam int sb_clear_remote_req_idx_gp = 0;
  localparam int sb_clear_div_req_idx_gp    = 1;

  typedef struct packed {
    logic                              v;
    logic [RV32_reg_addr_width_gp-1:0] id;
  } vanilla_sb_clear_req_s;

endpackage

// File: rtl/vanilla_sb_clear_channel.sv
// One register-file clear channel: round-robin arbiter with starvation override,
// per-requester wait counters and registered scoreboard-clear outputs.
module vanilla_sb_clear_channel #(
  parameter int els_p            = 3,
  parameter int starve_limit_p   = 8,
  parameter int reg_addr_width_p = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [els_p-1:0]                  req_v,
  input  logic [els_p*reg_addr_width_p-1:0] req_id,
  output logic [els_p-1:0]                  yumi,
  input  logic                              port_free,
  output logic                              sb_clear,
  output logic [reg_addr_width_p-1:0]       sb_clear_id
);

  localparam int unsigned n     = els_p;
  localparam int          ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int          cnt_w = $clog2(starve_limit_p + 1);

  logic [ptr_w-1:0]            rr_ptr;
  logic [ptr_w-1:0]            winner;
  logic [ptr_w-1:0]            scan;
  logic                        found;
  logic                        grant;
  logic [els_p-1:0]            starved;
  logic [cnt_w-1:0]            wait_cnt [els_p];
  logic [reg_addr_width_p-1:0] ids      [els_p];
  logic [reg_addr_width_p-1:0] winner_id;

  always_comb begin
    for (int unsigned i = 0; i < n; i++) begin
      ids[i]     = req_id[i*reg_addr_width_p +: reg_addr_width_p];
      starved[i] = (wait_cnt[i] == cnt_w'(starve_limit_p));
    end
  end

  // Starved requesters (lowest index first) pre-empt the round-robin scan.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!found && starved[i] && req_v[i]) begin
        winner = ptr_w'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned k = 0; k < n; k++) begin
      scan = ptr_w'((32'(rr_ptr) + k) % n);
      if (!found && req_v[scan]) begin
        winner = scan;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant     = port_free && (|req_v) && !reset;
    winner_id = ids[winner];
    yumi      = '0;
    if (grant) begin
      yumi[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      sb_clear    <= 1'b0;
      sb_clear_id <= '0;
    end else begin
      sb_clear <= grant;
      if (grant) begin
        sb_clear_id <= winner_id;
        rr_ptr      <= (winner == ptr_w'(n - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < n; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < n; i++) begin
        if (!req_v[i] || yumi[i]) begin
          wait_cnt[i] <= '0;
        end else if (!starved[i]) begin
          wait_cnt[i] <= wait_cnt[i] + cnt_w'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < els_p; g++) begin : g_contract
    a_hold : assert property (@(posedge clk) disable iff (reset)
      (req_v[g] && !yumi[g]) |=> (req_v[g] && $stable(ids[g])));
  end

endmodule

// File: rtl/vanilla_sb_clear_scheduler.sv
// Scoreboard-clear scheduler: independent int and float clear channels.
module vanilla_sb_clear_scheduler
  import bsg_vanilla_pkg::*;
#(
  parameter int els_p            = 3,
  parameter int starve_limit_p   = 8,
  parameter int reg_addr_width_p = RV32_reg_addr_width_gp
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [els_p-1:0]                  int_req_v_i,
  input  logic [els_p*reg_addr_width_p-1:0] int_req_id_i,
  output logic [els_p-1:0]                  int_req_yumi_o,
  input  logic                              int_port_free_i,
  output logic                              int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]       int_sb_clear_id_o,
  input  logic [els_p-1:0]                  float_req_v_i,
  input  logic [els_p*reg_addr_width_p-1:0] float_req_id_i,
  output logic [els_p-1:0]                  float_req_yumi_o,
  input  logic                              float_port_free_i,
  output logic                              float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]       float_sb_clear_id_o
);

  vanilla_sb_clear_channel #(
    .els_p           (els_p),
    .starve_limit_p  (starve_limit_p),
    .reg_addr_width_p(reg_addr_width_p)
  ) int_channel (
    .clk        (clk_i),
    .reset      (reset_i),
    .req_v      (int_req_v_i),
    .req_id     (int_req_id_i),
    .yumi       (int_req_yumi_o),
    .port_free  (int_port_free_i),
    .sb_clear   (int_sb_clear_o),
    .sb_clear_id(int_sb_clear_id_o)
  );

  vanilla_sb_clear_channel #(
    .els_p           (els_p),
    .starve_limit_p  (starve_limit_p),
    .reg_addr_width_p(reg_addr_width_p)
  ) float_channel (
    .clk        (clk_i),
    .reset      (reset_i),
    .req_v      (float_req_v_i),
    .req_id     (float_req_id_i),
    .yumi       (float_req_yumi_o),
    .port_free  (float_port_free_i),
    .sb_clear   (float_sb_clear_o),
    .sb_clear_id(float_sb_clear_id_o)
  );

endmodule

// File: tb/tb_vanilla_sb_clear_scheduler.sv
// Scoreboard bench: a per-cycle arbitration model pushes expected clears,
// a monitor pops and checks them when the DUT reports a clear.
module tb_vanilla_sb_clear_scheduler;
  import bsg_vanilla_pkg::*;

  localparam int N   = 3;
  localparam int W   = RV32_reg_addr_width_gp;
  localparam int LIM = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   int_v, int_yumi, fl_v, fl_yumi;
  logic [N*W-1:0] int_id, fl_id;
  logic           int_free, fl_free;
  logic           int_clr, fl_clr;
  logic [W-1:0]   int_cid, fl_cid;

  always #5 clk = ~clk;

  vanilla_sb_clear_scheduler #(
    .els_p           (N),
    .starve_limit_p  (LIM),
    .reg_addr_width_p(W)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .int_req_v_i        (int_v),
    .int_req_id_i       (int_id),
    .int_req_yumi_o     (int_yumi),
    .int_port_free_i    (int_free),
    .int_sb_clear_o     (int_clr),
    .int_sb_clear_id_o  (int_cid),
    .float_req_v_i      (fl_v),
    .float_req_id_i     (fl_id),
    .float_req_yumi_o   (fl_yumi),
    .float_port_free_i  (fl_free),
    .float_sb_clear_o   (fl_clr),
    .float_sb_clear_id_o(fl_cid)
  );

  typedef struct {
    logic [W-1:0] id;
    int           cyc;
  } exp_t;

  vanilla_sb_clear_req_s req [2][N];
  int                    age [2][N];
  int                    rr  [2];
  logic                  free_m [2];
  logic [W-1:0]          last_id [2];
  exp_t                  q_int[$], q_fl[$];
  int                    cyc = 0;
  int                    total = 0;
  int                    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      int_v[i]          = req[0][i].v;
      int_id[i*W +: W]  = req[0][i].id;
      fl_v[i]           = req[1][i].v;
      fl_id[i*W +: W]   = req[1][i].id;
    end
    int_free = free_m[0];
    fl_free  = free_m[1];
  endtask

  // Reference rule: grant needs a free port; oldest-limit waiter (lowest index)
  // beats the round-robin scan that starts at the pointer.
  function automatic int pick(input int ch);
    if (!free_m[ch]) return -1;
    for (int i = 0; i < N; i++)
      if (req[ch][i].v && age[ch][i] >= LIM) return i;
    for (int k = 0; k < N; k++)
      if (req[ch][(rr[ch] + k) % N].v) return (rr[ch] + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      rr[ch]      = 0;
      last_id[ch] = '0;
      for (int i = 0; i < N; i++) age[ch][i] = 0;
    end
  endtask

  task automatic step(input int mask0, input int mask1, input int rp, input int fp);
    int   w;
    int   mask;
    exp_t e;
    logic [N-1:0] exp_y;
    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      mask = (ch == 0) ? mask0 : mask1;
      for (int i = 0; i < N; i++) begin
        if (!req[ch][i].v && mask[i] && ($urandom_range(99) < rp)) begin
          req[ch][i].v  = 1'b1;
          req[ch][i].id = W'($urandom_range(31));
          age[ch][i]    = 0;
        end
      end
      free_m[ch] = ($urandom_range(99) < fp);
    end
    apply();
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      w     = pick(ch);
      exp_y = '0;
      if (w >= 0) exp_y[w] = 1'b1;
      if (ch == 0) chk("int_yumi", 32'(int_yumi), 32'(exp_y));
      else         chk("float_yumi", 32'(fl_yumi), 32'(exp_y));
      if (w >= 0) begin
        e.id  = req[ch][w].id;
        e.cyc = cyc + 1;
        if (ch == 0) q_int.push_back(e);
        else         q_fl.push_back(e);
        rr[ch] = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (i == w) begin
          req[ch][i].v = 1'b0;
          age[ch][i]   = 0;
        end else if (req[ch][i].v) begin
          age[ch][i] = (age[ch][i] + 1 > LIM) ? LIM : age[ch][i] + 1;
        end else begin
          age[ch][i] = 0;
        end
      end
    end
  endtask

  task automatic drain();
    int pend;
    for (int t = 0; t < 40; t++) begin
      pend = 0;
      for (int ch = 0; ch < 2; ch++)
        for (int i = 0; i < N; i++) pend += int'(req[ch][i].v);
      if (pend == 0) break;
      step(0, 0, 0, 100);
    end
  endtask

  task automatic mon(input int ch, input logic clr, input logic [W-1:0] cid);
    exp_t e;
    int   sz;
    sz = (ch == 0) ? q_int.size() : q_fl.size();
    if (sz > 0) begin
      e = (ch == 0) ? q_int[0] : q_fl[0];
      if (e.cyc < cyc) begin
        chk(ch == 0 ? "int_missed_clear" : "float_missed_clear", 32'(e.cyc), 32'(cyc));
        if (ch == 0) void'(q_int.pop_front());
        else         void'(q_fl.pop_front());
        sz--;
      end
    end
    if (clr) begin
      if (sz == 0) begin
        chk(ch == 0 ? "int_spurious_clear" : "float_spurious_clear", 32'(clr), 32'(0));
      end else begin
        e = (ch == 0) ? q_int.pop_front() : q_fl.pop_front();
        chk(ch == 0 ? "int_clear_id" : "float_clear_id", 32'(cid), 32'(e.id));
        chk(ch == 0 ? "int_clear_cycle" : "float_clear_cycle", 32'(cyc), 32'(e.cyc));
      end
      last_id[ch] = cid;
    end else begin
      chk(ch == 0 ? "int_id_hold" : "float_id_hold", 32'(cid), 32'(last_id[ch]));
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset) begin
      mon(0, int_clr, int_cid);
      mon(1, fl_clr, fl_cid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      free_m[ch] = 1'b0;
      for (int i = 0; i < N; i++) begin
        req[ch][i].v  = 1'b0;
        req[ch][i].id = '0;
      end
    end
    model_reset();
    apply();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_int_clear", 32'(int_clr), 32'(0));
    chk("reset_int_id", 32'(int_cid), 32'(0));
    chk("reset_float_clear", 32'(fl_clr), 32'(0));
    chk("reset_float_id", 32'(fl_cid), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // Reset while a clear is being presented, requests 0 and 1 held.
    step(3, 3, 100, 100);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_int_clear", 32'(int_clr), 32'(0));
    chk("midreset_float_clear", 32'(fl_clr), 32'(0));
    chk("midreset_int_yumi", 32'(int_yumi), 32'(0));
    chk("midreset_float_yumi", 32'(fl_yumi), 32'(0));
    chk("midreset_int_id", 32'(int_cid), 32'(0));
    model_reset();
    for (int ch = 0; ch < 2; ch++) req[ch][0].v = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(0, 0, 0, 100);
    drain();

    // Round-robin with everyone requesting.
    for (int t = 0; t < 6; t++) step(7, 7, 100, 100);
    drain();

    // Port busy: lone requester waits past the starvation limit.
    step(1, 1, 100, 0);
    for (int t = 0; t < 3; t++) step(0, 0, 0, 0);
    step(0, 0, 0, 100);
    drain();

    // Contention between two requesters with a flaky port.
    for (int t = 0; t < 40; t++) step(3, 3, 100, 50);
    drain();

    for (int t = 0; t < 400; t++) step(7, 7, 60, 70);
    drain();
    step(0, 0, 0, 100);
    step(0, 0, 0, 100);
    @(posedge clk);
    #2;
    chk("int_queue_empty", 32'(q_int.size()), 32'(0));
    chk("float_queue_empty", 32'(q_fl.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
